bin_to_ascii_seq: RTL and testbench

Sequential 8-bit binary to 3-character ASCII formatter. It sits downstream of the MCU core, between the core's 8-bit observation outputs (PC, W_reg, Alu_out) and the ASCII-to-seven-segment decoders on the board wrapper.
A value is captured on a start handshake and converted with an iterative shift-and-add-3 (double-dabble) engine. The block then presents three registered ASCII codes (hundreds/tens/ones, or hex marker/high nibble/low nibble) with a one-cycle done pulse.

---
 rtl/bin_to_ascii_seq.sv | 175 +++++++++++++++++
 tb/tb_bin_to_ascii_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_ascii_seq.sv
// bin_to_ascii_seq: sequential 8-bit binary to 3-char ASCII formatter.
// Double-dabble engine; decimal or hex with registered ASCII outputs.
module bin_to_ascii_seq #(
    parameter bit         BLANK_LZ = 1'b1,
    parameter logic [7:0] HEX_MARK = 8'h48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] value,
    input  logic       hex_mode,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] ascii_hi,
    output logic [7:0] ascii_med,
    output logic [7:0] ascii_lo
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FORMAT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_A  = 8'h41;

    state_t      r_state;
    state_t      w_state_nx;
    logic [19:0] r_work;
    logic [19:0] w_work_nx;
    logic [19:0] w_work_adj;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nx;
    logic        r_hex;
    logic        w_hex_nx;
    logic [7:0]  r_hi;
    logic [7:0]  r_med;
    logic [7:0]  r_lo;
    logic [7:0]  w_hi_nx;
    logic [7:0]  w_med_nx;
    logic [7:0]  w_lo_nx;
    logic [7:0]  w_fmt_hi;
    logic [7:0]  w_fmt_med;
    logic [7:0]  w_fmt_lo;
    logic [3:0]  w_d2;
    logic [3:0]  w_d1;
    logic [3:0]  w_d0;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] n);
        return CH_0 + {4'h0, n};
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] w_ch;
        if (n < 4'd10) begin
            w_ch = CH_0 + {4'h0, n};
        end else begin
            w_ch = CH_A + {4'h0, n - 4'd10};
        end
        return w_ch;
    endfunction

    // BCD correction applied before each shift in decimal mode
    always_comb begin
        w_work_adj = {add3(r_work[19:16]),
                      add3(r_work[15:12]),
                      add3(r_work[11:8]),
                      r_work[7:0]};
    end

    assign w_d2 = r_work[19:16];
    assign w_d1 = r_work[15:12];
    assign w_d0 = r_work[11:8];

    always_comb begin
        w_fmt_hi  = CH_SP;
        w_fmt_med = CH_SP;
        w_fmt_lo  = CH_0;
        if (r_hex) begin
            w_fmt_hi  = HEX_MARK;
            w_fmt_med = hex_char(w_d1);
            w_fmt_lo  = hex_char(w_d0);
        end else begin
            w_fmt_hi  = dec_char(w_d2);
            w_fmt_med = dec_char(w_d1);
            w_fmt_lo  = dec_char(w_d0);
            // the ones digit always shows, so "  0" is the blanked zero
            if (BLANK_LZ && (w_d2 == 4'd0)) begin
                w_fmt_hi = CH_SP;
                if (w_d1 == 4'd0) begin
                    w_fmt_med = CH_SP;
                end
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_work_nx  = r_work;
        w_cnt_nx   = r_cnt;
        w_hex_nx   = r_hex;
        w_hi_nx    = r_hi;
        w_med_nx   = r_med;
        w_lo_nx    = r_lo;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_work_nx  = {12'h000, value};
                    w_hex_nx   = hex_mode;
                    w_cnt_nx   = 3'd0;
                    w_state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_hex) begin
                    w_work_nx = {r_work[18:0], 1'b0};
                end else begin
                    w_work_nx = {w_work_adj[18:0], 1'b0};
                end
                w_cnt_nx = r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    w_state_nx = S_FORMAT;
                end
            end
            S_FORMAT: begin
                w_hi_nx    = w_fmt_hi;
                w_med_nx   = w_fmt_med;
                w_lo_nx    = w_fmt_lo;
                w_state_nx = S_DONE;
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_work  <= 20'h00000;
            r_cnt   <= 3'd0;
            r_hex   <= 1'b0;
            r_hi    <= CH_SP;
            r_med   <= CH_SP;
            r_lo    <= CH_0;
        end else begin
            r_state <= w_state_nx;
            r_work  <= w_work_nx;
            r_cnt   <= w_cnt_nx;
            r_hex   <= w_hex_nx;
            r_hi    <= w_hi_nx;
            r_med   <= w_med_nx;
            r_lo    <= w_lo_nx;
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign busy      = ~ready;
    assign done      = (r_state == S_DONE);
    assign ascii_hi  = r_hi;
    assign ascii_med = r_med;
    assign ascii_lo  = r_lo;

endmodule

// File: tb/tb_bin_to_ascii_seq.sv
// tb_bin_to_ascii_seq: directed bench for bin_to_ascii_seq.
// Two instances: default blanking and BLANK_LZ=0.
module tb_bin_to_ascii_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] value;
    logic       hex_mode;

    logic       ready, busy, done;
    logic [7:0] a_hi, a_med, a_lo;
    logic       b_ready, b_busy, b_done;
    logic [7:0] b_hi, b_med, b_lo;

    int n_cmp = 0;
    int n_err = 0;

    bin_to_ascii_seq u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .hex_mode  (hex_mode),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .ascii_hi  (a_hi),
        .ascii_med (a_med),
        .ascii_lo  (a_lo)
    );

    bin_to_ascii_seq #(.BLANK_LZ(1'b0)) u_nlz (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .hex_mode  (hex_mode),
        .ready     (b_ready),
        .busy      (b_busy),
        .done      (b_done),
        .ascii_hi  (b_hi),
        .ascii_med (b_med),
        .ascii_lo  (b_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [7:0] v, input logic h,
                           input string tag, input logic [23:0] ea,
                           input logic [23:0] eb);
        int k;
        k = 0;
        while (!ready && k < 20) begin
            tick();
            k++;
        end
        value    = v;
        hex_mode = h;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        chk({tag, ".lat"}, k, 32'd9);
        chk({tag, ".txt"}, {8'h0, a_hi, a_med, a_lo}, {8'h0, ea});
        chk({tag, ".nlz"}, {8'h0, b_hi, b_med, b_lo}, {8'h0, eb});
        chk({tag, ".bdone"}, {31'd0, b_done}, 32'd1);
        tick();
        chk({tag, ".done1"}, {31'd0, done}, 32'd0);
        chk({tag, ".rdy"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  vals [3];
        logic [23:0] exps [3];
        int          idx;
        int          ndone;
        logic        hold;

        reset    = 1'b1;
        start    = 1'b0;
        value    = 8'd0;
        hex_mode = 1'b0;
        #3;
        chk("rst.txt", {8'h0, a_hi, a_med, a_lo}, 32'h00202030);
        chk("rst.done", {31'd0, done}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        chk("rst.rdy", {30'd0, ready, busy}, 32'd2);

        convert(8'd255, 1'b0, "d255", 24'h323535, 24'h323535);
        convert(8'd0, 1'b0, "d0", 24'h202030, 24'h303030);
        convert(8'd7, 1'b0, "d7", 24'h202037, 24'h303037);
        convert(8'd105, 1'b0, "d105", 24'h313035, 24'h313035);
        convert(8'd20, 1'b0, "d20", 24'h203230, 24'h303230);
        convert(8'hAF, 1'b1, "hAF", 24'h484146, 24'h484146);
        convert(8'h09, 1'b1, "h09", 24'h483039, 24'h483039);

        // requests during a conversion are dropped
        value    = 8'd200;
        hex_mode = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("ign.rdy%0d", k), {31'd0, ready}, 32'd0);
            chk($sformatf("ign.done%0d", k), {31'd0, done},
                (k == 9) ? 32'd1 : 32'd0);
            start = (k == 3 || k == 9);
            value = (k == 3 || k == 9) ? 8'd33 : 8'd200;
        end
        chk("ign.txt", {8'h0, a_hi, a_med, a_lo}, 32'h00323030);
        tick();
        start = 1'b0;
        chk("ign.rdy", {31'd0, ready}, 32'd1);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("ign.ndone", ndone, 32'd0);
        chk("ign.hold", {8'h0, a_hi, a_med, a_lo}, 32'h00323030);

        // reset in the middle of a conversion
        value = 8'd123;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        #1;
        chk("mrst.txt", {8'h0, a_hi, a_med, a_lo}, 32'h00202030);
        chk("mrst.st", {29'd0, done, ready, busy}, 32'd2);
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("mrst.ndone", ndone, 32'd0);
        convert(8'd99, 1'b0, "d99", 24'h203939, 24'h303939);

        // start held high: accepts every 11 clocks
        vals[0] = 8'd1;
        vals[1] = 8'd2;
        vals[2] = 8'd3;
        exps[0] = 24'h202031;
        exps[1] = 24'h202032;
        exps[2] = 24'h202033;
        idx      = 0;
        hold     = 1'b0;
        value    = vals[0];
        hex_mode = 1'b0;
        start    = 1'b1;
        tick();
        value = 8'hEE;
        for (int c = 1; c <= 31; c++) begin
            tick();
            if (done) begin
                if (idx < 3) begin
                    chk($sformatf("b2b.cyc%0d", idx), c, 9 + 11 * idx);
                    chk($sformatf("b2b.txt%0d", idx),
                        {8'h0, a_hi, a_med, a_lo}, {8'h0, exps[idx]});
                end
                idx++;
                if (idx < 3) value = vals[idx];
                hold = 1'b1;
            end else if (hold) begin
                hold = 1'b0;
            end else begin
                value = 8'hEE;
            end
        end
        start = 1'b0;
        chk("b2b.count", idx, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
